vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter HLINES, default 640: active pixels per line.
REQ-002 Parameter VLINES, default 480: active lines per frame.
REQ-003 Parameter HBP, default 57: pixel_clk cycles from the HS-deassert edge to the first active pixel.
REQ-004 Parameter VBP, default 41: HS-deassert edges from frame reference (vcnt=0) to the first active line.
REQ-005 Parameter SPP, default 0: sync-pulse polarity; HS/VS are asserted when equal to SPP.
REQ-006 Parameter LOCK_FRAMES, default 2: consecutive matching frames required for lock.
REQ-007 Port pixel_clk, input, 1: sole clock; all logic updates on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Ports hs, vs, input, 1 each: incoming sync signals, already in the pixel_clk domain.
REQ-010 Ports r_in, g_in, b_in, input, 4 each: incoming colour.
REQ-011 Ports x, y, output, 11 each: coordinates of the current output pixel.
REQ-012 Ports r_out, g_out, b_out, output, 4 each: registered colour aligned with x/y.
REQ-013 Port pixel_valid, output, 1: output pixel lies in the active area and the receiver is LOCKED.
REQ-014 Ports line_start, frame_start, output, 1 each: single-cycle pulses at x=0 of each active line and at (0,0).
REQ-015 Port locked, output, 1: FSM is in LOCKED.
REQ-016 Ports htotal_meas, vtotal_meas, output, 11 each: last measured clocks/line and lines/frame.
REQ-017 Ports frame_crc, output, 16, and crc_valid, output, 1: per-frame checksum, see Configuration.

Function
REQ-018 The block shall register hs/vs/rgb once (stage 1); edges are detected between stage 1 and its delayed copy.
REQ-019 An HS-deassert edge (stage-1 value changes from SPP to ~SPP) shall clear hcnt to 0; otherwise hcnt increments, saturating at 2047.
REQ-020 A VS-deassert edge shall set vs_pending; the next HS-deassert edge shall clear vcnt to 0 and vs_pending; other HS-deassert edges increment vcnt, saturating at 2047.
REQ-021 When HS and VS deassert in the same cycle, that HS edge shall also clear vcnt.
REQ-022 Active area: HBP <= hcnt < HBP+HLINES and VBP <= vcnt < VBP+VLINES, with x=hcnt-HBP and y=vcnt-VBP.
REQ-023 Latency: rgb sampled at the input in cycle N shall appear on r/g/b_out, with matching x/y/pixel_valid, in cycle N+2.
REQ-024 htotal_meas shall load hcnt+1 at each HS-deassert edge; vtotal_meas shall load vcnt+1 when vcnt is cleared.
REQ-025 A frame matches when every line's htotal equals the first line's and vtotal equals the previous frame's vtotal.
REQ-026 FSM SEARCH: on the first VS-deassert edge, go to ACQUIRE with match count 0.
REQ-027 FSM ACQUIRE: at each frame end, a matching frame increments the count and a mismatch clears it; count == LOCK_FRAMES goes to LOCKED.
REQ-028 FSM LOCKED: a mismatching frame, or 2048 cycles without an HS edge, shall go to SEARCH, with locked=0 on the next cycle.
REQ-029 pixel_valid, line_start and frame_start shall be 0 outside LOCKED.
REQ-030 A frame end in progress when LOCKED is entered shall not generate a frame_start.

Reset
REQ-031 During reset the block shall set: FSM SEARCH; hcnt, vcnt, x, y, rgb_out, htotal_meas, vtotal_meas, frame_crc all 0; pixel_valid, line_start, frame_start, locked, crc_valid, vs_pending all 0.
REQ-032 Reset asserted mid-frame shall abandon the frame, with no pulses and no crc_valid; re-lock then takes at least LOCK_FRAMES+1 VS edges.

Configuration
REQ-033 With macro VGA_RX_CRC_EN defined, frame_crc shall hold CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {r,g,b} of every valid pixel in raster order.
REQ-034 With VGA_RX_CRC_EN defined, the result shall update on the cycle after the last active pixel of a LOCKED frame, with crc_valid pulsing 1 cycle.
REQ-035 With VGA_RX_CRC_EN undefined, frame_crc shall be constant 0, crc_valid constant 0, and no CRC logic shall be synthesized.

Verification
REQ-036 Drive the team's 640x480 generator stream (801x526) with defaults: locked rises at end of frame 3; htotal_meas=801, vtotal_meas=526.
REQ-037 Pixel with rgb=0xF00 at generator (0,0): r_out=F, x=0, y=0, pixel_valid=1 and frame_start=1, exactly 2 cycles after the input sample.
REQ-038 Lengthen one line to 802 clocks while LOCKED: locked drops after that frame and relocks after 2 clean frames.
REQ-039 Hold hs constant for 2048 cycles while LOCKED: FSM goes to SEARCH and locked=0; no further pixel_valid.
REQ-040 Assert reset at line 200 of a LOCKED frame: all outputs 0 next cycle; no crc_valid for that frame.
REQ-041 With VGA_RX_CRC_EN and all pixels 0x000: frame_crc equals the reference model's CRC over 307200 zero 12-bit words, and crc_valid pulses once per frame.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Recovers raster timing from incoming HS/VS, measures line/frame totals,
// locks once the timing has been stable for LOCK_FRAMES frames, and emits
// coordinates and colour aligned two cycles after the input sample.
// Optional feature: define VGA_RX_CRC_EN to build the per-frame CRC-16-CCITT
// over {r,g,b} of every valid pixel; without it frame_crc/crc_valid are tied 0.
module vga_sync_receiver #(
    parameter int   HLINES      = 640,
    parameter int   VLINES      = 480,
    parameter int   HBP         = 57,
    parameter int   VBP         = 41,
    parameter logic SPP         = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic        pixel_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] htotal_meas,
    output logic [10:0] vtotal_meas,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_LO    = 11'(HBP);
    localparam logic [10:0] H_HI    = 11'(HBP + HLINES);
    localparam logic [10:0] V_LO    = 11'(VBP);
    localparam logic [10:0] V_HI    = 11'(VBP + VLINES);

    state_t      state;
    logic [7:0]  match_cnt;

    logic        hs_p1, vs_p1, hs_p2, vs_p2;
    logic [3:0]  r_p1, g_p1, b_p1;

    logic [10:0] hcnt_q, vcnt_q, hcnt_p1, vcnt_p1;
    logic [10:0] hto_q;
    logic        vs_pending;
    logic [10:0] ht_ref;
    logic        first_line, line_bad;

    logic        hs_deassert, vs_deassert, hs_toggle, frame_end, timeout;
    logic [10:0] htotal_new, vtotal_new;
    logic        line_mismatch, frame_match;
    logic        act_p1, vld_p1;
    logic [10:0] x_p1, y_p1;

    // Stage 1: sync signals and their delayed copy for edge detection
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hs_p1 <= ~SPP;
            vs_p1 <= ~SPP;
            hs_p2 <= ~SPP;
            vs_p2 <= ~SPP;
        end else begin
            hs_p1 <= hs;
            vs_p1 <= vs;
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
        end
    end

    // Stage 1: colour capture (pure data path, no reset needed)
    always_ff @(posedge pixel_clk) begin
        r_p1 <= r_in;
        g_p1 <= g_in;
        b_p1 <= b_in;
    end

    assign hs_deassert = (hs_p2 == SPP) && (hs_p1 != SPP);
    assign vs_deassert = (vs_p2 == SPP) && (vs_p1 != SPP);
    assign hs_toggle   = (hs_p1 != hs_p2);
    // A VS edge in the same cycle as the HS edge closes the frame immediately
    assign frame_end   = hs_deassert && (vs_pending || vs_deassert);
    assign timeout     = (hto_q == CNT_MAX);
    assign htotal_new  = hcnt_q + 11'd1;
    assign vtotal_new  = vcnt_q + 11'd1;

    // Counter values belonging to the sample currently in stage 1
    always_comb begin
        hcnt_p1 = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
        vcnt_p1 = vcnt_q;
        if (hs_deassert) begin
            hcnt_p1 = 11'd0;
            if (frame_end)
                vcnt_p1 = 11'd0;
            else if (vcnt_q != CNT_MAX)
                vcnt_p1 = vcnt_q + 11'd1;
        end
    end

    // Frame matches when no line deviated from the first and vtotal repeats
    always_comb begin
        line_mismatch = !first_line && (htotal_new != ht_ref);
        frame_match   = !(line_bad || line_mismatch) && (vtotal_new == vtotal_meas);
    end

    // Raster counters, pending-VS flag and HS activity timeout
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hcnt_q     <= 11'd0;
            vcnt_q     <= 11'd0;
            vs_pending <= 1'b0;
            hto_q      <= 11'd0;
        end else begin
            hcnt_q <= hcnt_p1;
            vcnt_q <= vcnt_p1;
            if (frame_end)
                vs_pending <= 1'b0;
            else if (vs_deassert)
                vs_pending <= 1'b1;
            if (hs_toggle)
                hto_q <= 11'd0;
            else if (!timeout)
                hto_q <= hto_q + 11'd1;
        end
    end

    // Line/frame total measurement and per-frame consistency tracking
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            htotal_meas <= 11'd0;
            vtotal_meas <= 11'd0;
            ht_ref      <= 11'd0;
            first_line  <= 1'b1;
            line_bad    <= 1'b0;
        end else if (hs_deassert) begin
            htotal_meas <= htotal_new;
            if (frame_end) begin
                vtotal_meas <= vtotal_new;
                first_line  <= 1'b1;
                line_bad    <= 1'b0;
            end else if (first_line) begin
                ht_ref     <= htotal_new;
                first_line <= 1'b0;
            end else if (line_mismatch) begin
                line_bad <= 1'b1;
            end
        end
    end

    // Lock FSM: SEARCH -> ACQUIRE on VS, LOCKED after LOCK_FRAMES matches
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state     <= SEARCH;
            match_cnt <= 8'd0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_deassert) begin
                        state     <= ACQUIRE;
                        match_cnt <= 8'd0;
                    end
                end
                ACQUIRE: begin
                    if (frame_end) begin
                        if (frame_match) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt + 8'd1 == 8'(LOCK_FRAMES))
                                state <= LOCKED;
                        end else begin
                            match_cnt <= 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if ((frame_end && !frame_match) || timeout)
                        state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        act_p1 = (hcnt_p1 >= H_LO) && (hcnt_p1 < H_HI) &&
                 (vcnt_p1 >= V_LO) && (vcnt_p1 < V_HI);
        x_p1   = hcnt_p1 - H_LO;
        y_p1   = vcnt_p1 - V_LO;
        vld_p1 = act_p1 && locked;
    end

    // Stage 2: registered pixel outputs aligned with their coordinates
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            x           <= 11'd0;
            y           <= 11'd0;
            r_out       <= 4'd0;
            g_out       <= 4'd0;
            b_out       <= 4'd0;
            pixel_valid <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= act_p1 ? x_p1 : 11'd0;
            y           <= act_p1 ? y_p1 : 11'd0;
            r_out       <= r_p1;
            g_out       <= g_p1;
            b_out       <= b_p1;
            pixel_valid <= vld_p1;
            line_start  <= vld_p1 && (x_p1 == 11'd0);
            frame_start <= vld_p1 && (x_p1 == 11'd0) && (y_p1 == 11'd0);
        end
    end

`ifdef VGA_RX_CRC_EN
    // CRC-16-CCITT (poly 0x1021), one 12-bit word, MSB first
    function automatic logic [15:0] crc16_step12(input logic [15:0] crc, input logic [11:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ d[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_acc, crc_seed, crc_next;
    logic        crc_run, last_pix;

    always_comb begin
        crc_seed = frame_start ? 16'hFFFF : crc_acc;
        crc_next = crc16_step12(crc_seed, {r_out, g_out, b_out});
        last_pix = pixel_valid && (crc_run || frame_start) &&
                   (x == 11'(HLINES - 1)) && (y == 11'(VLINES - 1));
    end

    // Stage 3: accumulate over valid pixels, publish after the last one
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            crc_run   <= 1'b0;
            frame_crc <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (pixel_valid) begin
                crc_acc <= crc_next;
                if (frame_start)
                    crc_run <= 1'b1;
                if (last_pix) begin
                    frame_crc <= crc_next;
                    crc_valid <= 1'b1;
                    crc_run   <= 1'b0;
                end
            end
            if (!locked)
                crc_run <= 1'b0;
        end
    end
`else
    assign frame_crc = 16'd0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled raster (30 clocks x 14 lines,
// 16x8 active) so several lock/unlock scenarios fit in a short run.
module tb_vga_sync_receiver;

    localparam int HL  = 16;
    localparam int VL  = 8;
    localparam int HB  = 5;
    localparam int VB  = 3;
    localparam int HT  = 30;
    localparam int VT  = 14;
    localparam int HSW = 4;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic [3:0]  r_in = 4'd0, g_in = 4'd0, b_in = 4'd0;
    logic [10:0] x, y, htotal_meas, vtotal_meas;
    logic [3:0]  r_out, g_out, b_out;
    logic        pixel_valid, line_start, frame_start, locked, crc_valid;
    logic [15:0] frame_crc;

    int n_cmp = 0;
    int n_bad = 0;
    int crc_pulses = 0;
    bit rst_chk = 0;

    typedef struct packed {
        bit          en;
        bit          vld;
        bit          ls;
        bit          fs;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [11:0] rgb;
        logic [7:0]  fno;
    } exp_t;

    exp_t pipe0 = '0;
    exp_t pipe1 = '0;

    vga_sync_receiver #(
        .HLINES(HL), .VLINES(VL), .HBP(HB), .VBP(VB), .SPP(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset), .hs(hs), .vs(vs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .htotal_meas(htotal_meas), .vtotal_meas(vtotal_meas),
        .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int px, input int py);
        logic [11:0] w;
        if (px == 0 && py == 0)
            w = 12'hF00;
        else
            w = {px[3:0], py[3:0], 4'hA};
        return w;
    endfunction

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic [11:0] w;
        logic        fb;
        c = 16'hFFFF;
        for (int py = 0; py < VL; py++)
            for (int px = 0; px < HL; px++) begin
                w = pix(px, py);
                for (int b = 11; b >= 0; b--) begin
                    fb = c[15] ^ w[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        return c;
    endfunction
    logic [15:0] crc_ref;
`endif

    // One pixel clock: check what is due at this negedge, then drive inputs
    task automatic step(input logic h, input logic v, input logic [11:0] c,
                        input bit rst_now, input exp_t e);
        string tag;
        @(negedge pixel_clk);
        if (pipe1.en) begin
            tag = $sformatf("f%0d(%0d,%0d)", pipe1.fno, pipe1.ex, pipe1.ey);
            chk({tag, ".valid"}, pixel_valid, pipe1.vld);
            if (pipe1.vld) begin
                chk({tag, ".x"}, x, pipe1.ex);
                chk({tag, ".y"}, y, pipe1.ey);
                chk({tag, ".rgb"}, {r_out, g_out, b_out}, pipe1.rgb);
                chk({tag, ".line_start"}, line_start, pipe1.ls);
                chk({tag, ".frame_start"}, frame_start, pipe1.fs);
            end
        end
        if (rst_chk) begin
            chk("rst.locked", locked, 0);
            chk("rst.pixel_valid", pixel_valid, 0);
            chk("rst.x", x, 0);
            chk("rst.y", y, 0);
            chk("rst.rgb", {r_out, g_out, b_out}, 0);
            chk("rst.line_start", line_start, 0);
            chk("rst.frame_start", frame_start, 0);
            chk("rst.htotal", htotal_meas, 0);
            chk("rst.vtotal", vtotal_meas, 0);
            chk("rst.crc_valid", crc_valid, 0);
            chk("rst.frame_crc", frame_crc, 0);
            rst_chk = 0;
        end
        if (crc_valid) begin
            crc_pulses++;
`ifdef VGA_RX_CRC_EN
            chk("frame_crc", frame_crc, crc_ref);
`endif
        end
        pipe1 = pipe0;
        pipe0 = e;
        if (rst_now) rst_chk = 1;
        reset = rst_now;
        hs    = h;
        vs    = v;
        {r_in, g_in, b_in} = c;
    endtask

    // mode 0: no pixel checks, 1: locked-frame spot checks, 2: (0,0) must be invalid
    task automatic frame(input int fno, input int l0, input int mode, input int exp_lock,
                         input int long_line, input int rst_line);
        for (int l = l0; l < VT; l++) begin
            int len;
            len = (l == long_line) ? HT + 1 : HT;
            for (int k = 0; k < len; k++) begin
                logic h, v;
                logic [11:0] c;
                bit act;
                int px, py;
                exp_t e;
                h   = (k >= len - HSW) ? 1'b0 : 1'b1;
                v   = (l >= VT - 2) ? 1'b0 : 1'b1;
                px  = k - HB;
                py  = l - VB;
                act = (px >= 0 && px < HL && py >= 0 && py < VL);
                c   = act ? pix(px, py) : 12'h000;
                e   = '0;
                e.fno = 8'(fno);
                if (mode == 1 && act && ((px == 0 && py == 0) || (px == 1 && py == 0) ||
                    (px == HL - 1 && py == VL - 1) || (px == 0 && py == 2))) begin
                    e.en  = 1;
                    e.vld = 1;
                    e.ls  = (px == 0);
                    e.fs  = (px == 0 && py == 0);
                    e.ex  = 11'(px);
                    e.ey  = 11'(py);
                    e.rgb = c;
                end else if (mode == 1 && l == VB && (k == HB - 1 || k == HB + HL)) begin
                    e.en = 1;
                    e.ex = 11'(k);
                    e.ey = 11'(l);
                end else if (mode == 2 && px == 0 && py == 0) begin
                    e.en = 1;
                end
                step(h, v, c, (l == rst_line && k == 0), e);
                if (l == 2 && k == 10 && exp_lock >= 0)
                    chk($sformatf("f%0d.locked", fno), locked, exp_lock);
                if (l == 2 && k == 10 && mode == 1) begin
                    chk($sformatf("f%0d.htotal", fno), htotal_meas, HT);
                    chk($sformatf("f%0d.vtotal", fno), vtotal_meas, VT);
                end
                if (long_line >= 0 && l == long_line + 1 && k == 10)
                    chk($sformatf("f%0d.htotal_long", fno), htotal_meas, HT + 1);
            end
        end
    endtask

    initial begin
`ifdef VGA_RX_CRC_EN
        crc_ref = crc_model();
`endif
        repeat (3) step(1'b1, 1'b1, 12'h000, 1'b1, '0);
        frame(0, VT - 2, 0, -1, -1, -1);   // preamble: VS asserted lines
        frame(1, 0, 0, 0, -1, -1);
        frame(2, 0, 0, 0, -1, -1);
        frame(3, 0, 2, 0, -1, -1);
        frame(4, 0, 1, 1, -1, -1);         // locked after end of frame 3
        frame(5, 0, 1, 1, 5, -1);          // one 31-clock line
        frame(6, 0, 2, 0, -1, -1);
        frame(7, 0, 0, 0, -1, -1);
        frame(8, 0, 2, 0, -1, -1);
        frame(9, 0, 0, 1, -1, 5);          // reset mid-frame while locked
        frame(10, 0, 0, 0, -1, -1);
        frame(11, 0, 0, 0, -1, -1);
        frame(12, 0, 2, 0, -1, -1);
        frame(13, 0, 1, 1, -1, -1);
        repeat (2100) step(1'b1, 1'b1, 12'h000, 1'b0, '0);
        chk("timeout.locked", locked, 0);
        chk("timeout.pixel_valid", pixel_valid, 0);
        frame(14, 0, 2, 0, -1, -1);
        repeat (3) step(1'b1, 1'b1, 12'h000, 1'b0, '0);
`ifdef VGA_RX_CRC_EN
        chk("crc_pulses", crc_pulses, 3);
`else
        chk("crc_pulses", crc_pulses, 0);
        chk("frame_crc_const", frame_crc, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
